lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_ctrl.sv | 128 ++++++++++++
 tb/tb_lcd_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 write sequencer with a one-entry pending buffer.
// Each word runs SETUP -> PULSE -> HOLD -> WAIT with timing set by parameters.
module lcd_ctrl #(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned EN_CYC       = 12,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned WAIT_CYC     = 2000,
    parameter int unsigned CLR_WAIT_CYC = 82000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] lcd_word_i,
    input  logic        lcd_wr_i,
    output logic        lcd_busy_o,
    output logic        lcd_full_o,
    output logic        lcd_err_o,
    output logic        lcd_on_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o
);
    localparam int unsigned CNT_W = $clog2(SETUP_CYC + EN_CYC + HOLD_CYC + WAIT_CYC + CLR_WAIT_CYC);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [8:0]         buf_q, buf_d;
    logic               full_q, full_d;
    logic               err_q, err_d;
    logic               on_q, on_d;
    logic               rs_q, rs_d;
    logic [7:0]         data_q, data_d;
    logic               en_q, busy_q;
    logic               last, drop, is_clr;
    logic               unused_w;

    assign unused_w = ^lcd_word_i[30:9];

    always_comb begin
        last    = cnt_q == '0;
        drop    = lcd_wr_i && state_q != IDLE && full_q;
        is_clr  = !rs_q && data_q inside {8'h01, 8'h02, 8'h03};
        state_d = state_q;
        cnt_d   = last ? cnt_q : cnt_q - CNT_W'(1);
        rs_d    = rs_q;
        data_d  = data_q;
        buf_d   = buf_q;
        full_d  = full_q;
        err_d   = err_q | drop;
        on_d    = (lcd_wr_i && !drop) ? lcd_word_i[31] : on_q;
        case (state_q)
            IDLE: if (lcd_wr_i) begin
                state_d          = SETUP;
                cnt_d            = CNT_W'(SETUP_CYC - 1);
                {rs_d, data_d}   = lcd_word_i[8:0];
            end
            SETUP: if (last) begin
                state_d = PULSE;
                cnt_d   = CNT_W'(EN_CYC - 1);
            end
            PULSE: if (last) begin
                state_d = HOLD;
                cnt_d   = CNT_W'(HOLD_CYC - 1);
            end
            HOLD: if (last) begin
                state_d = WAIT;
                cnt_d   = is_clr ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(WAIT_CYC - 1);
            end
            WAIT: if (last) begin
                if (full_q) begin
                    state_d        = SETUP;
                    cnt_d          = CNT_W'(SETUP_CYC - 1);
                    {rs_d, data_d} = buf_q;
                    full_d         = 1'b0;
                end else if (lcd_wr_i) begin
                    state_d        = SETUP;
                    cnt_d          = CNT_W'(SETUP_CYC - 1);
                    {rs_d, data_d} = lcd_word_i[8:0];
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // a word arriving on the final WAIT cycle goes straight out instead of into the buffer
        if (lcd_wr_i && state_q != IDLE && !full_q && !(state_q == WAIT && last)) begin
            buf_d  = lcd_word_i[8:0];
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            on_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            err_q   <= err_d;
            on_q    <= on_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= state_d == PULSE;
            busy_q  <= state_d != IDLE;
        end
    end

    assign lcd_busy_o = busy_q;
    assign lcd_full_o = full_q;
    assign lcd_err_o  = err_q;
    assign lcd_on_o   = on_q;
    assign lcd_en_o   = en_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_data_o = data_q;
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed and random checks of lcd_ctrl against a timeline model.
module tb_lcd_ctrl;
    localparam int SU = 1, EN = 2, HO = 1, WT = 4, CW = 10;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] lcd_word_i = '0;
    logic        lcd_wr_i = 1'b0;
    logic        lcd_busy_o, lcd_full_o, lcd_err_o, lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o;
    logic [7:0]  lcd_data_o;

    int checks = 0, errors = 0;
    int cyc = 0;
    int en_n, busy_n, full_n;

    // model: the active word occupies the cycle window [m_s, m_end]
    logic       tx, m_full, m_err, m_on;
    logic [8:0] m_w, m_buf;
    int         m_s, m_end;

    lcd_ctrl #(.SETUP_CYC(SU), .EN_CYC(EN), .HOLD_CYC(HO), .WAIT_CYC(WT), .CLR_WAIT_CYC(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .lcd_word_i(lcd_word_i), .lcd_wr_i(lcd_wr_i),
        .lcd_busy_o(lcd_busy_o), .lcd_full_o(lcd_full_o), .lcd_err_o(lcd_err_o),
        .lcd_on_o(lcd_on_o), .lcd_en_o(lcd_en_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o),
        .lcd_data_o(lcd_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        tx = 0; m_full = 0; m_err = 0; m_on = 0; m_w = '0; m_buf = '0; m_s = 0; m_end = -1;
    endtask

    task automatic start(input int s, input logic [8:0] w);
        tx = 1; m_s = s; m_w = w;
        m_end = s + SU + EN + HO + ((!w[8] && w[7:0] inside {8'h01, 8'h02, 8'h03}) ? CW : WT) - 1;
    endtask

    task automatic chk_all();
        chk("busy", 32'(lcd_busy_o), 32'(tx && cyc <= m_end));
        chk("en", 32'(lcd_en_o), 32'(tx && cyc >= m_s + SU && cyc < m_s + SU + EN));
        chk("rs", 32'(lcd_rs_o), 32'(m_w[8]));
        chk("data", 32'(lcd_data_o), 32'(m_w[7:0]));
        chk("full", 32'(lcd_full_o), 32'(m_full));
        chk("err", 32'(lcd_err_o), 32'(m_err));
        chk("on", 32'(lcd_on_o), 32'(m_on));
        chk("rw", 32'(lcd_rw_o), 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_outs", {22'(0), lcd_busy_o, lcd_full_o, lcd_err_o, lcd_on_o, lcd_en_o, lcd_rs_o,
                         lcd_rw_o, 1'b0, 1'b0, 1'b0}, 32'd0);
        chk("rst_data", 32'(lcd_data_o), 32'd0);
    endtask

    // one clock: present inputs, advance model at the edge, compare at the falling edge
    task automatic step(input logic wr, input logic [31:0] word);
        logic busy_c, lastw, bv;
        lcd_wr_i = wr; lcd_word_i = word;
        @(posedge clk_i);
        busy_c = tx && cyc <= m_end;
        lastw  = busy_c && cyc == m_end;
        bv     = m_full;
        if (lastw && bv) begin start(cyc + 1, m_buf); m_full = 0; end
        if (wr) begin
            if (!busy_c || (lastw && !bv)) begin start(cyc + 1, word[8:0]); m_on = word[31]; end
            else if (!bv) begin m_buf = word[8:0]; m_full = 1; m_on = word[31]; end
            else m_err = 1;
        end
        cyc++;
        @(negedge clk_i);
        lcd_wr_i = 1'b0;
        chk_all();
        en_n   += int'(lcd_en_o);
        busy_n += int'(lcd_busy_o);
        full_n += int'(lcd_full_o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; lcd_wr_i = 1'b0;
        #1 chk_reset_vals();
        model_clear();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc = 0; en_n = 0; busy_n = 0; full_n = 0;
    endtask

    initial begin
        model_clear();
        @(posedge clk_i);
        @(negedge clk_i);
        chk_reset_vals();
        rst_ni = 1'b1;
        cyc = 0; en_n = 0; busy_n = 0; full_n = 0;
        // single data write
        step(1'b1, 32'h8000_0141);
        chk("p037_on", 32'(lcd_on_o), 32'd1);
        chk("p037_data", 32'(lcd_data_o), 32'h41);
        idle(10);
        chk("p037_en_cycles", 32'(en_n), 32'd2);
        chk("p037_busy_cycles", 32'(busy_n), 32'd8);
        // clear command uses the long wait
        do_reset();
        step(1'b1, 32'h8000_0001);
        idle(16);
        chk("p038_busy_cycles", 32'(busy_n), 32'd14);
        // second write is buffered
        do_reset();
        step(1'b1, 32'h141); idle(2); step(1'b1, 32'h142);
        idle(20);
        chk("p039_full_cycles", 32'(full_n), 32'd5);
        chk("p039_en_cycles", 32'(en_n), 32'd4);
        chk("p039_data", 32'(lcd_data_o), 32'h42);
        // third write dropped
        do_reset();
        step(1'b1, 32'h141); idle(1); step(1'b1, 32'h142); step(1'b1, 32'h143);
        idle(20);
        chk("p040_err", 32'(lcd_err_o), 32'd1);
        chk("p040_data", 32'(lcd_data_o), 32'h42);
        // write on the final WAIT cycle bypasses the buffer
        do_reset();
        step(1'b1, 32'h141); idle(7); step(1'b1, 32'h155);
        idle(12);
        chk("p041_full_cycles", 32'(full_n), 32'd0);
        chk("p041_en_cycles", 32'(en_n), 32'd4);
        // asynchronous reset in the middle of the EN pulse
        do_reset();
        step(1'b1, 32'h8000_0141); step(1'b0, 32'h0); step(1'b1, 32'h142);
        chk("p042_en_before", 32'(lcd_en_o), 32'd1);
        do_reset();
        idle(12);
        chk("p042_en_after", 32'(en_n), 32'd0);
        // random traffic with a reset before each block
        for (int b = 0; b < 6; b++) begin
            do_reset();
            for (int i = 0; i < 400; i++) begin
                logic [7:0] d;
                d = $urandom_range(0, 1) ? 8'($urandom_range(0, 5)) : 8'($urandom);
                step(1'($urandom_range(0, 5) == 0),
                     {1'($urandom), 22'($urandom), 1'($urandom), d});
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
